// File: rtl/g11620_pixel_capture_if.sv
// rtl/g11620_pixel_capture_if.sv - packed pixel word stream from the capture stage to the host DMA/FIFO
interface g11620_pixel_capture_if;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_in;

  // Capture stage drives words out; the DMA/FIFO side returns ready
  modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_in);
  modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_in);
endinterface

// File: rtl/g11620_pixel_capture.sv
// rtl/g11620_pixel_capture.sv - G11620 line capture: packs ADC pixels into a line buffer, then streams the line out
// Optional feature macro: G11620_CAP_TEST_PATTERN_EN (replace ADC samples with the pixel index).
module g11620_pixel_capture #(
  parameter int PIX_NUM = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm_in,
  input  logic                   soft_reset_in,
  input  logic                   ad_sp,
  input  logic                   adc_valid_in,
  input  logic [15:0]            adc_data_in,
  g11620_pixel_capture_if.master m_if,
  output logic                   line_done_o,
  output logic                   overflow_o,
  output logic                   busy_o
);

  localparam int WORDS = PIX_NUM / 2;
  localparam int PCW   = $clog2(PIX_NUM);
  // A two-pixel line still needs a one-bit word address
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [PCW-1:0] LAST_PIX  = PCW'(PIX_NUM - 1);
  localparam logic [WAW-1:0] LAST_WORD = WAW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_READOUT} state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pix_q, pix_d;
  logic [15:0]    hold_q, hold_d;
  logic [WAW-1:0] rd_addr_q, rd_addr_d;
  logic           rd_all_q, rd_all_d;
  logic           s1_valid_q, s1_valid_d;
  logic           s1_last_q, s1_last_d;
  logic [31:0]    m_data_q, m_data_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic           line_done_q, line_done_d;
  logic           overflow_q, overflow_d;

  logic [31:0]    mem_q [WORDS];
  logic [31:0]    mem_rdata_q;

  logic           cap_en;
  logic           rd_phase;
  logic           advance;
  logic           last_xfer;
  logic           rd_en;
  logic           wr_en;
  logic [WAW-1:0] wr_addr;
  logic [31:0]    wr_data;
  logic [15:0]    sample;

`ifdef G11620_CAP_TEST_PATTERN_EN
  logic unused_adc_data;
  assign unused_adc_data = ^adc_data_in;
  assign sample = 16'(pix_q);
`else
  assign sample = adc_data_in;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an abort overrides every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm_in) state_d = S_ARM;
      S_ARM:     if (ad_sp) state_d = S_CAPTURE;
      S_CAPTURE: if (adc_valid_in && (pix_q == LAST_PIX)) state_d = S_READOUT;
      S_READOUT: if (last_xfer) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (soft_reset_in) state_d = S_IDLE;
  end

  // FSM outputs and phase enables
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    cap_en    = (state_q == S_CAPTURE) && adc_valid_in && !soft_reset_in;
    rd_phase  = (state_q == S_READOUT) && !soft_reset_in;
    advance   = !m_valid_q || m_if.m_ready_in;
    last_xfer = m_valid_q && m_if.m_ready_in && m_last_q;
  end

  // Buffer port controls: odd pixels complete a word; reads run ahead whenever the pipe has room
  always_comb begin
    wr_en   = cap_en && pix_q[0];
    wr_addr = WAW'(pix_q >> 1);
    wr_data = {sample, hold_q};
    rd_en   = rd_phase && !rd_all_q && (!s1_valid_q || advance);
  end

  // Datapath next values: pixel packing, read prefetch stage and output register
  always_comb begin
    pix_d       = pix_q;
    hold_d      = hold_q;
    rd_addr_d   = rd_addr_q;
    rd_all_d    = rd_all_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    line_done_d = last_xfer;
    overflow_d  = overflow_q;

    if ((state_q == S_ARM) && ad_sp) pix_d = '0;

    if (cap_en) begin
      if (!pix_q[0]) hold_d = sample;
      // The terminal compare ends capture, so the counter never wraps
      if (pix_q == LAST_PIX) pix_d = '0;
      else                   pix_d = pix_q + PCW'(1);
    end

    // Output register takes the prefetched word whenever it is empty or being consumed
    if (advance) begin
      m_valid_d = s1_valid_q;
      m_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) m_data_d = mem_rdata_q;
    end

    if (rd_en) begin
      s1_valid_d = 1'b1;
      s1_last_d  = (rd_addr_q == LAST_WORD);
      if (rd_addr_q == LAST_WORD) rd_all_d = 1'b1;
      else                        rd_addr_d = rd_addr_q + WAW'(1);
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (last_xfer) begin
      rd_addr_d = '0;
      rd_all_d  = 1'b0;
    end

    if ((state_q == S_IDLE) && arm_in) overflow_d = 1'b0;
    else if (ad_sp && ((state_q == S_CAPTURE) || (state_q == S_READOUT))) overflow_d = 1'b1;

    // Abort drops any in-flight word but keeps the overflow record
    if (soft_reset_in) begin
      pix_d       = '0;
      rd_addr_d   = '0;
      rd_all_d    = 1'b0;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      m_valid_d   = 1'b0;
      m_last_d    = 1'b0;
      line_done_d = 1'b0;
      overflow_d  = overflow_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q       <= '0;
      hold_q      <= '0;
      rd_addr_q   <= '0;
      rd_all_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pix_q       <= pix_d;
      hold_q      <= hold_d;
      rd_addr_q   <= rd_addr_d;
      rd_all_q    <= rd_all_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      line_done_q <= line_done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Line buffer: one write port, one registered read port (RAM-style, no reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) mem_rdata_q <= mem_q[rd_addr_q];
  end

  assign m_if.m_data_o  = m_data_q;
  assign m_if.m_valid_o = m_valid_q;
  assign m_if.m_last_o  = m_last_q;
  assign line_done_o    = line_done_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_g11620_pixel_capture.sv
// tb/tb_g11620_pixel_capture.sv - directed scoreboard bench for g11620_pixel_capture
module tb_g11620_pixel_capture;
  localparam int PIX   = 512;
  localparam int WORDS = PIX / 2;
`ifdef G11620_CAP_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, arm_in, soft_reset_in, ad_sp, adc_valid_in;
  logic [15:0] adc_data_in;
  logic        line_done_o, overflow_o, busy_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  g11620_pixel_capture_if bus();

  g11620_pixel_capture #(.PIX_NUM(PIX)) dut (
    .clk           (clk),
    .rst           (rst),
    .arm_in        (arm_in),
    .soft_reset_in (soft_reset_in),
    .ad_sp         (ad_sp),
    .adc_valid_in  (adc_valid_in),
    .adc_data_in   (adc_data_in),
    .m_if          (bus),
    .line_done_o   (line_done_o),
    .overflow_o    (overflow_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pv(input int p, input logic [15:0] d);
    return TP ? 16'(p) : d;
  endfunction

  task automatic arm();
    arm_in = 1'b1;
    step();
    arm_in = 1'b0;
    chk("arm_busy", busy_o, 1);
    chk("arm_ovf_clear", overflow_o, 0);
  endtask

  task automatic capture(input logic [15:0] base, input int gap, input int ovf_at,
                         input int abort_at, input bit sp_with_valid);
    logic [15:0] held;
    logic [15:0] d;
    held = '0;
    ad_sp = 1'b1;
    adc_valid_in = sp_with_valid;
    adc_data_in = 16'hDEAD;
    step();
    ad_sp = 1'b0;
    adc_valid_in = 1'b0;
    chk("cap_busy", busy_o, 1);
    for (int p = 0; p < PIX; p++) begin
      if (p > 0) repeat (gap) step();
      d = base + 16'(p);
      adc_valid_in = 1'b1;
      adc_data_in = d;
      ad_sp = (p == ovf_at);
      soft_reset_in = (p == abort_at);
      step();
      adc_valid_in = 1'b0;
      ad_sp = 1'b0;
      soft_reset_in = 1'b0;
      if (p == abort_at) begin
        exp_q.delete();
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", bus.m_valid_o, 0);
        return;
      end
      if (p % 2 == 0) held = pv(p, d);
      else exp_q.push_back({pv(p, d), held});
      if (p == ovf_at) chk("ovf_set_capture", overflow_o, 1);
    end
    chk("lat_T", bus.m_valid_o, 0);
    step();
    chk("lat_T1", bus.m_valid_o, 0);
    step();
    chk("lat_T2", bus.m_valid_o, 1);
  endtask

  task automatic readout(input int mode, input int sp_at);
    bit          prev_stall;
    bit          done;
    bit          rdy;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] exp;
    int          i;
    prev_stall = 1'b0;
    done = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    i = 0;
    while (!done && i < 4 * WORDS + 20) begin
      rdy = (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      bus.m_ready_in = rdy;
      ad_sp = (i == sp_at);
      if (prev_stall) begin
        chk("stall_valid", bus.m_valid_o, 1);
        chk("stall_data", bus.m_data_o, prev_data);
        chk("stall_last", bus.m_last_o, prev_last);
      end
      prev_stall = bus.m_valid_o && !rdy;
      prev_data = bus.m_data_o;
      prev_last = bus.m_last_o;
      if (bus.m_valid_o && rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
          done = 1'b1;
        end else begin
          exp = exp_q.pop_front();
          chk("word_data", bus.m_data_o, exp);
          chk("word_last", bus.m_last_o, (exp_q.size() == 0) ? 1 : 0);
          if (bus.m_last_o) done = 1'b1;
        end
      end
      step();
      ad_sp = 1'b0;
      i++;
    end
    if (!done) begin
      chk("readout_timeout", 0, 1);
    end else begin
      chk("line_done_high", line_done_o, 1);
      chk("busy_after_done", busy_o, 0);
      step();
      chk("line_done_pulse", line_done_o, 0);
      chk("valid_after_done", bus.m_valid_o, 0);
    end
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    arm_in = 1'b0;
    soft_reset_in = 1'b0;
    ad_sp = 1'b0;
    adc_valid_in = 1'b0;
    adc_data_in = '0;
    bus.m_ready_in = 1'b0;
    repeat (3) step();
    chk("rst_valid", bus.m_valid_o, 0);
    chk("rst_data", bus.m_data_o, 0);
    chk("rst_last", bus.m_last_o, 0);
    chk("rst_line_done", line_done_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;
    step();

    // Strobes in IDLE are ignored
    ad_sp = 1'b1;
    adc_valid_in = 1'b1;
    step();
    ad_sp = 1'b0;
    step();
    adc_valid_in = 1'b0;
    chk("idle_ignore_busy", busy_o, 0);
    chk("idle_ignore_ovf", overflow_o, 0);

    // Nominal line, full-rate capture and readout
    bus.m_ready_in = 1'b1;
    arm();
    capture(16'h0000, 0, -1, -1, 1'b0);
    readout(0, -1);
    chk("nominal_ovf", overflow_o, 0);

    // Backpressure 1-0-0-1
    arm();
    capture(16'hA000, 0, -1, -1, 1'b0);
    readout(1, -1);

    // Sparse valids, with strobes in ARM and alongside ad_sp
    arm();
    adc_valid_in = 1'b1;
    adc_data_in = 16'hBEEF;
    step();
    adc_valid_in = 1'b0;
    chk("arm_stays", busy_o, 1);
    capture(16'h3000, 2, -1, -1, 1'b1);
    readout(0, -1);

    // Overflow during capture and readout
    arm();
    capture(16'h5000, 0, 100, -1, 1'b0);
    readout(0, 7);
    chk("ovf_sticky", overflow_o, 1);

    // Abort then a clean line
    arm();
    capture(16'h7000, 0, -1, 300, 1'b0);
    repeat (5) step();
    chk("abort_no_output", bus.m_valid_o, 0);
    chk("abort_idle", busy_o, 0);
    arm();
    capture(16'h7100, 0, -1, -1, 1'b0);
    readout(0, -1);

    // Reset during READOUT
    bus.m_ready_in = 1'b0;
    arm();
    capture(16'h9000, 0, -1, -1, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_valid", bus.m_valid_o, 0);
    chk("midrst_data", bus.m_data_o, 0);
    chk("midrst_last", bus.m_last_o, 0);
    chk("midrst_line_done", line_done_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_busy", busy_o, 0);
    rst = 1'b0;
    exp_q.delete();
    step();
    chk("postrst_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/g11620_pixel_capture.md
# g11620_pixel_capture

Downstream capture stage for the G11620 line-sensor controller. Once armed, it waits for the sensor start pulse `ad_sp`, collects PIX_NUM 16-bit ADC samples, and packs them two per 32-bit word into an internal line buffer. It then streams the finished line out over a valid/ready interface toward the host DMA/FIFO. It shares the sensor clock domain with the controller.

## Interface
- `PIX_NUM`, 512: pixels per line; must be even, range 2..1024.
- `clk`  in  1  system clock; same clock as the G11620 controller.
- `rst`  in  1  synchronous reset, active-high.
- `arm_in`  in  1  single-cycle pulse from the controller's start; arms capture of one line.
- `soft_reset_in`  in  1  synchronous abort of the current line.
- `ad_sp`  in  1  sensor data-start strobe.
- `adc_valid_in`  in  1  ADC sample strobe.
- `adc_data_in`  in  16  ADC sample.
- `m_data_o`  out  32  packed pixel word: even pixel in [15:0], odd pixel in [31:16].
- `m_valid_o`  out  1  output word valid.
- `m_last_o`  out  1  marks the final word of the line; valid only while `m_valid_o` is high.
- `m_ready_in`  in  1  downstream ready.
- `line_done_o`  out  1  one-cycle pulse after the last word's handshake.
- `overflow_o`  out  1  sticky flag: `ad_sp` arrived while a line was being captured or read out.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: `arm_in` moves to ARM. `overflow_o` clears on `arm_in`.
  - ARM: `ad_sp` moves to CAPTURE. The pixel counter clears.
  - CAPTURE: each `adc_valid_in` takes one pixel.
    - Pixel index `p` counts 0..PIX_NUM-1.
    - Even `p` latches the sample into a 16-bit holding register.
    - Odd `p` writes {sample, holding} to buffer address `p>>1`.
    - When `p == PIX_NUM-1` is written, move to READOUT.
  - READOUT: buffer words 0..PIX_NUM/2-1 are emitted in order. After the handshake of the last word, pulse `line_done_o` and return to IDLE.
- Line buffer: PIX_NUM/2 × 32-bit, synchronous read with 1-cycle latency, one write port and one read port.
- Handshake:
  - A word transfers on any cycle with `m_valid_o & m_ready_in`.
  - While `m_ready_in` is low, `m_data_o` and `m_last_o` hold stable.
  - `m_valid_o` never drops before the handshake completes.
  - The read address is prefetched so that back-to-back transfers proceed at one word per cycle when `m_ready_in` stays high.
- Ignored inputs:
  - `adc_valid_in` outside CAPTURE.
  - `arm_in` outside IDLE.
  - `ad_sp` in IDLE.
- `ad_sp` in CAPTURE or READOUT sets `overflow_o`. The current line continues unaffected.
- Counter widths: pixel counter is clog2(PIX_NUM) bits; word address is clog2(PIX_NUM/2) bits. The counters do not wrap; the terminal-count compare ends the phase.
- `soft_reset_in` (any state):
  - Next state is IDLE.
  - `m_valid_o` goes to 0 on the next edge and the counters clear.
  - `overflow_o` is kept.
  - Buffer contents are don't-care.
- Simultaneous events:
  - `soft_reset_in` wins over all other events.
  - `ad_sp` together with `adc_valid_in` in ARM: the sample is not captured; capture starts at the next strobe.

## Timing
- Reset values: all outputs are 0, `m_data_o` = 0, state = IDLE.
- ARM→CAPTURE: the edge after `ad_sp` is sampled high.
- The final pixel write edge is cycle T. The state becomes READOUT at T, and `m_valid_o` rises at T+2 (buffer read latency).
- Readout throughput is 1 word/cycle. Minimum readout is PIX_NUM/2 cycles.
- `line_done_o` is high in the cycle after the `m_last_o` handshake. `busy_o` falls in that same cycle.
- Capture rate is one sample per cycle maximum; `adc_valid_in` may be asserted continuously.

## Configuration
- `G11620_CAP_TEST_PATTERN_EN`:
  - Defined: during CAPTURE, the sampled value is replaced by {pixel-index zero-extended to 16 bits}. `adc_data_in` is unused, but `adc_valid_in` timing is still honoured.
  - Undefined: `adc_data_in` is captured as-is.

## Test plan
- Nominal line: PIX_NUM=512 with test pattern on, arm, `ad_sp`, 512 consecutive valids, `m_ready_in`=1 → 256 words, word k = {2k+1, 2k}, `m_last_o` on word 255, one `line_done_o` pulse, `overflow_o`=0.
- Backpressure: ADC data 0xA000+p, `m_ready_in` toggling 1-0-0-1 → no word dropped or duplicated, data stable while stalled, word 0 = 0xA001A000.
- Sparse valids: valid every 3rd cycle, `adc_valid_in` also pulsed in IDLE and ARM → exactly 512 samples taken, the out-of-window strobes are ignored, first `m_valid_o` at T+2.
- Overflow: second `ad_sp` at pixel 100, and again during READOUT → `overflow_o`=1 sticky, line output intact; the next `arm_in` clears it.
- Abort: `soft_reset_in` at pixel 300, then a new arm and full line → no output from the aborted line, the second line is correct, `busy_o` low one cycle after the abort.
- Reset: `rst` asserted mid-READOUT → all outputs are 0 on the next edge, state IDLE.
